// File: rtl/crc_check.sv
// Serial CRC-16 receiver/checker: divides a framed MSB-first codeword by POLY and flags pass/fail.
// Optional build macro CRC_ERR_COUNT_EN adds the saturating ERR_COUNT output.
`timescale 1ns/1ps
module crc_check #(
  parameter int          DATA_W = 16,
  parameter int          CRC_W  = 16,
  parameter logic [15:0] POLY   = 16'h8005,
  parameter logic [15:0] INIT   = 16'h0000
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic              BIT_VALID,
  input  logic              BIT_IN,
  output logic              BUSY,
  output logic              DONE,
  output logic              CRC_OK,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic [15:0]       REMAINDER
`ifdef CRC_ERR_COUNT_EN
  ,
  output logic [7:0]        ERR_COUNT
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_DONE} state_t;

  localparam logic [5:0] DATA_LIM = 6'(DATA_W);
  localparam logic [5:0] LAST_CNT = 6'(DATA_W + CRC_W - 1);

  state_t            state_reg, state_next;
  logic [15:0]       rem_reg, rem_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic [5:0]        count_reg, count_next;
  logic              done_reg, done_next;
  logic              crc_ok_reg, crc_ok_next;
  logic [DATA_W-1:0] data_out_reg, data_out_next;
  logic [15:0]       remainder_reg, remainder_next;
  logic [7:0]        err_reg, err_next;

  logic [15:0]       rem_step;
  logic [DATA_W-1:0] data_shift;

  assign rem_step = {rem_reg[14:0], BIT_IN} ^ (rem_reg[15] ? POLY : 16'h0000);

  generate
    if (DATA_W == 1) begin : g_shift_one
      assign data_shift = BIT_IN;
    end else begin : g_shift_many
      assign data_shift = {data_reg[DATA_W-2:0], BIT_IN};
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_reg     <= S_IDLE;
      rem_reg       <= 16'h0000;
      data_reg      <= '0;
      count_reg     <= 6'd0;
      done_reg      <= 1'b0;
      crc_ok_reg    <= 1'b0;
      data_out_reg  <= '0;
      remainder_reg <= 16'h0000;
      err_reg       <= 8'h00;
    end else begin
      state_reg     <= state_next;
      rem_reg       <= rem_next;
      data_reg      <= data_next;
      count_reg     <= count_next;
      done_reg      <= done_next;
      crc_ok_reg    <= crc_ok_next;
      data_out_reg  <= data_out_next;
      remainder_reg <= remainder_next;
      err_reg       <= err_next;
    end
  end

  // Result registers load on the final accepted bit so they are visible in the DONE cycle.
  always_comb begin
    state_next     = state_reg;
    rem_next       = rem_reg;
    data_next      = data_reg;
    count_next     = count_reg;
    done_next      = 1'b0;
    crc_ok_next    = crc_ok_reg;
    data_out_next  = data_out_reg;
    remainder_next = remainder_reg;
    err_next       = err_reg;
    case (state_reg)
      S_IDLE: begin
        if (START) begin
          rem_next   = INIT;
          data_next  = '0;
          count_next = 6'd0;
          state_next = S_RECV;
        end
      end
      S_RECV: begin
        if (START) begin
          rem_next   = INIT;
          data_next  = '0;
          count_next = 6'd0;
        end else if (BIT_VALID) begin
          rem_next   = rem_step;
          count_next = count_reg + 6'd1;
          if (count_reg < DATA_LIM) data_next = data_shift;
          if (count_reg == LAST_CNT) begin
            state_next     = S_DONE;
            done_next      = 1'b1;
            crc_ok_next    = (rem_step == 16'h0000);
            remainder_next = rem_step;
            data_out_next  = data_reg;
            if (rem_step != 16'h0000 && err_reg != 8'hFF) err_next = err_reg + 8'd1;
          end
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign BUSY      = (state_reg == S_RECV);
  assign DONE      = done_reg;
  assign CRC_OK    = crc_ok_reg;
  assign DATA_OUT  = data_out_reg;
  assign REMAINDER = remainder_reg;
`ifdef CRC_ERR_COUNT_EN
  assign ERR_COUNT = err_reg;
`endif

endmodule
